// File: rtl/pwm_shadow_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_shadow_bank
//  Description : Per-channel shadow/active register bank for PWM compare and
//                period values. Software writes land in the shadow registers
//                and move to the active registers on a qualifying PWM counter
//                event (after an event-skip count), on force_load, or every
//                cycle while PWM is off or in immediate mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_shadow_bank #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SKW   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pwm_on,
  input  logic                     evt_zero,
  input  logic                     evt_period,
  input  logic [1:0]               upd_mode,
  input  logic [SKW-1:0]           mask_n,
  input  logic                     force_load,
  input  logic                     wr_en,
  input  logic [$clog2(NCH)-1:0]   wr_ch,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [NCH*WIDTH-1:0]     active_out,
  output logic [NCH-1:0]           pending,
  output logic                     load_pulse
);

  localparam logic [1:0]     MODE_IMM    = 2'b00;
  localparam logic [1:0]     MODE_ZERO   = 2'b01;
  localparam logic [1:0]     MODE_PERIOD = 2'b10;
  localparam logic [1:0]     MODE_BOTH   = 2'b11;
  localparam logic [SKW-1:0] CNT_MAX     = {SKW{1'b1}};

  logic [NCH-1:0][WIDTH-1:0] shadow;
  logic [NCH-1:0][WIDTH-1:0] active;
  logic [SKW-1:0]            evt_cnt;
  logic [NCH-1:0]            wr_hit;
  logic                      masked;
  logic                      qe;
  logic                      ld;

  // Write decode: one-hot channel select, out-of-range channels dropped.
  always_comb begin
    wr_hit = '0;
    if (wr_en && (32'(wr_ch) < NCH)) begin
      wr_hit[wr_ch] = 1'b1;
    end
  end

  // Qualifying event and load decision; zero and period together are one event.
  always_comb begin
    masked = pwm_on && (upd_mode != MODE_IMM);
    case (upd_mode)
      MODE_ZERO:   qe = evt_zero;
      MODE_PERIOD: qe = evt_period;
      MODE_BOTH:   qe = evt_zero | evt_period;
      default:     qe = 1'b0;
    endcase
    ld = !masked || force_load || (qe && (evt_cnt >= mask_n));
  end

  // Event-skip counter: only counts while masked, clears on every masked load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_cnt <= '0;
    end else if (!masked || ld) begin
      evt_cnt <= '0;
    end else if (qe && (evt_cnt != CNT_MAX)) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

  // Shadow/active/pending registers; a same-cycle write keeps its pending bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (ld) begin
          active[k]  <= shadow[k];
          pending[k] <= 1'b0;
        end
        if (wr_hit[k]) begin
          shadow[k]  <= wr_data;
          pending[k] <= 1'b1;
        end
      end
    end
  end

  // Transfer strobe: only when a load actually moved pending data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_pulse <= 1'b0;
    end else begin
      load_pulse <= ld && (|pending);
    end
  end

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_pack
      assign active_out[g*WIDTH +: WIDTH] = active[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_shadow_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_shadow_bank
//  Description : Self-checking bench for pwm_shadow_bank: a hand-computed
//                vector table, a mid-operation asynchronous reset check and a
//                randomized run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_shadow_bank;

  localparam int WIDTH = 16;
  localparam int NCH   = 3;   // non power of two so an out-of-range channel exists
  localparam int SKW   = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pwm_on, evt_zero, evt_period, force_load, wr_en;
  logic [1:0]             upd_mode;
  logic [SKW-1:0]         mask_n;
  logic [1:0]             wr_ch;
  logic [WIDTH-1:0]       wr_data;
  logic [NCH*WIDTH-1:0]   active_out;
  logic [NCH-1:0]         pending;
  logic                   load_pulse;

  int tests = 0;
  int fails = 0;

  pwm_shadow_bank #(.WIDTH(WIDTH), .NCH(NCH), .SKW(SKW)) dut (
    .clk(clk), .reset(reset), .pwm_on(pwm_on), .evt_zero(evt_zero),
    .evt_period(evt_period), .upd_mode(upd_mode), .mask_n(mask_n),
    .force_load(force_load), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .active_out(active_out), .pending(pending), .load_pulse(load_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pwm;
    logic        ez;
    logic        ep;
    logic [1:0]  mode;
    logic [3:0]  mask;
    logic        frc;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] data;
    logic [47:0] exp_act;
    logic [2:0]  exp_pend;
    logic        exp_pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pwm, logic ez, logic ep, logic [1:0] mode,
                              logic [3:0] mask, logic frc, logic we, logic [1:0] ch,
                              logic [15:0] data, logic [47:0] ea, logic [2:0] epd,
                              logic epl);
    vec_t v;
    v.pwm = pwm; v.ez = ez; v.ep = ep; v.mode = mode; v.mask = mask; v.frc = frc;
    v.we = we; v.ch = ch; v.data = data; v.exp_act = ea; v.exp_pend = epd;
    v.exp_pulse = epl;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic pwm, logic ez, logic ep, logic [1:0] mode, logic [3:0] mask,
                       logic frc, logic we, logic [1:0] ch, logic [15:0] data);
    pwm_on = pwm; evt_zero = ez; evt_period = ep; upd_mode = mode; mask_n = mask;
    force_load = frc; wr_en = we; wr_ch = ch; wr_data = data;
  endtask

  // Behavioural reference state
  int unsigned m_shadow [NCH];
  int unsigned m_active [NCH];
  bit          m_pending[NCH];
  int          m_cnt;
  bit          m_pulse;

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_shadow[k] = 0; m_active[k] = 0; m_pending[k] = 0;
    end
    m_cnt = 0; m_pulse = 0;
  endfunction

  // Advance the model by one clock edge using the current input values.
  function automatic void model_step();
    bit masked, qe, ld, any;
    int ch;
    masked = pwm_on && (upd_mode != 0);
    case (upd_mode)
      2'd1:    qe = evt_zero;
      2'd2:    qe = evt_period;
      2'd3:    qe = evt_zero || evt_period;
      default: qe = 0;
    endcase
    ld  = !masked || force_load || (qe && (m_cnt >= int'(mask_n)));
    any = 0;
    for (int k = 0; k < NCH; k++) any |= m_pending[k];
    m_pulse = ld && any;
    if (ld) begin
      for (int k = 0; k < NCH; k++) begin
        m_active[k] = m_shadow[k]; m_pending[k] = 0;
      end
    end
    ch = int'(wr_ch);
    if (wr_en && ch < NCH) begin
      m_shadow[ch] = wr_data; m_pending[ch] = 1;
    end
    if (!masked || ld) m_cnt = 0;
    else if (qe)       m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
  endfunction

  function automatic logic [47:0] model_act();
    logic [47:0] v;
    for (int k = 0; k < NCH; k++) v[k*16 +: 16] = m_active[k][15:0];
    return v;
  endfunction

  function automatic logic [2:0] model_pend();
    logic [2:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_pending[k];
    return v;
  endfunction

  initial begin
    // Table: each row is applied for one cycle, outputs checked after the edge.
    vecs.push_back(mk(1,0,0,2'd0,4'd0,0,1,2'd2,16'h00FF, 48'h0000_0000_0000, 3'b100, 0));
    vecs.push_back(mk(0,0,0,2'd0,4'd0,0,0,2'd0,16'h0000, 48'h00FF_0000_0000, 3'b000, 1));
    vecs.push_back(mk(0,0,0,2'd0,4'd0,0,0,2'd0,16'h0000, 48'h00FF_0000_0000, 3'b000, 0));
    vecs.push_back(mk(1,0,0,2'd1,4'd2,0,1,2'd0,16'h0400, 48'h00FF_0000_0000, 3'b001, 0));
    vecs.push_back(mk(1,1,0,2'd1,4'd2,0,0,2'd0,16'h0000, 48'h00FF_0000_0000, 3'b001, 0));
    vecs.push_back(mk(1,0,0,2'd1,4'd2,0,0,2'd0,16'h0000, 48'h00FF_0000_0000, 3'b001, 0));
    vecs.push_back(mk(1,1,0,2'd1,4'd2,0,0,2'd0,16'h0000, 48'h00FF_0000_0000, 3'b001, 0));
    vecs.push_back(mk(1,1,0,2'd1,4'd2,0,0,2'd0,16'h0000, 48'h00FF_0000_0400, 3'b000, 1));
    vecs.push_back(mk(1,0,0,2'd1,4'd2,0,0,2'd0,16'h0000, 48'h00FF_0000_0400, 3'b000, 0));
    vecs.push_back(mk(1,1,1,2'd3,4'd1,0,1,2'd1,16'h0555, 48'h00FF_0000_0400, 3'b010, 0));
    vecs.push_back(mk(1,0,1,2'd3,4'd1,0,1,2'd1,16'h0AAA, 48'h00FF_0555_0400, 3'b010, 1));
    vecs.push_back(mk(1,1,0,2'd3,4'd0,0,0,2'd0,16'h0000, 48'h00FF_0AAA_0400, 3'b000, 1));
    vecs.push_back(mk(1,0,1,2'd2,4'd5,0,1,2'd0,16'h1111, 48'h00FF_0AAA_0400, 3'b001, 0));
    vecs.push_back(mk(1,0,0,2'd2,4'd5,1,1,2'd3,16'hBEEF, 48'h00FF_0AAA_1111, 3'b000, 1));
    vecs.push_back(mk(1,0,0,2'd2,4'd1,0,1,2'd2,16'h2222, 48'h00FF_0AAA_1111, 3'b100, 0));
    vecs.push_back(mk(1,0,1,2'd2,4'd1,0,0,2'd0,16'h0000, 48'h00FF_0AAA_1111, 3'b100, 0));
    vecs.push_back(mk(1,0,1,2'd2,4'd1,0,0,2'd0,16'h0000, 48'h2222_0AAA_1111, 3'b000, 1));
    vecs.push_back(mk(0,0,0,2'd2,4'd1,0,1,2'd1,16'h3333, 48'h2222_0AAA_1111, 3'b010, 0));
    vecs.push_back(mk(0,0,0,2'd2,4'd1,0,0,2'd0,16'h0000, 48'h2222_3333_1111, 3'b000, 1));

    reset = 1'b1;
    drive(0,0,0,2'd0,4'd0,0,0,2'd0,16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_active",  64'(active_out), 64'h0);
    check("reset_pending", 64'(pending),    64'h0);
    check("reset_pulse",   64'(load_pulse), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].pwm, vecs[i].ez, vecs[i].ep, vecs[i].mode, vecs[i].mask,
            vecs[i].frc, vecs[i].we, vecs[i].ch, vecs[i].data);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_active", i),  64'(active_out), 64'(vecs[i].exp_act));
      check($sformatf("vec%0d_pending", i), 64'(pending),    64'(vecs[i].exp_pend));
      check($sformatf("vec%0d_pulse", i),   64'(load_pulse), 64'(vecs[i].exp_pulse));
    end

    // Asynchronous reset in the middle of activity, away from any clock edge.
    @(negedge clk);
    drive(0,0,0,2'd0,4'd0,0,1,2'd0,16'h1234);
    @(negedge clk);
    drive(0,0,0,2'd0,4'd0,0,1,2'd1,16'h0077);
    @(posedge clk);
    #1;
    check("pre_reset_active0", 64'(active_out[15:0]), 64'h1234);
    check("pre_reset_pulse",   64'(load_pulse),       64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_active",  64'(active_out), 64'h0);
    check("async_reset_pending", 64'(pending),    64'h0);
    check("async_reset_pulse",   64'(load_pulse), 64'h0);
    @(negedge clk);
    drive(0,0,0,2'd0,4'd0,0,0,2'd0,16'h0);
    reset = 1'b0;
    model_reset();

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)),
            16'($urandom));
      model_step();
      @(posedge clk);
      #1;
      check("rand_active",  64'(active_out), 64'(model_act()));
      check("rand_pending", 64'(pending),    64'(model_pend()));
      check("rand_pulse",   64'(load_pulse), 64'(m_pulse));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
